// File: rtl/i2c_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : i2c_reg_sequencer
// Description : Table-driven I2C register-write sequencer that feeds tokens to
//               an I2C master, retries NACKed entries and reports Done/Error.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_reg_sequencer #(
    parameter int                      NUM_WRITES = 8,
    parameter logic [7:0]              SLAVE_ADDR = 8'h72,
    parameter logic [NUM_WRITES*16-1:0] TABLE     = '0,
    parameter int                      MAX_RETRY  = 3,
    parameter int                      RETRY_GAP  = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic [1:0] Op,
    output logic [7:0] Data,
    output logic       Valid,
    input  logic       Ready,
    input  logic       Nack,
    output logic       Busy,
    output logic       Done,
    output logic       Error
);

    localparam int c_IDX_W = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1;
    localparam int c_RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int c_GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
    localparam int c_DEPTH = 1 << c_IDX_W;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(NUM_WRITES - 1);
    localparam logic [c_RTY_W-1:0] c_MAX_RETRY = c_RTY_W'(MAX_RETRY);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST  = c_GAP_W'((RETRY_GAP > 0) ? RETRY_GAP - 1 : 0);

    localparam logic [1:0] c_OP_STOP    = 2'd0;
    localparam logic [1:0] c_OP_START   = 2'd1;
    localparam logic [1:0] c_OP_CONT    = 2'd2;
    localparam logic [1:0] c_OP_RESTART = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_REG  = 3'd2,
        S_VAL  = 3'd3,
        S_STOP = 3'd4,
        S_GAP  = 3'd5,
        S_DONE = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    // Table padded to a power of two so the index always selects in range
    logic [15:0] w_tbl [c_DEPTH];

    for (genvar i = 0; i < c_DEPTH; i++) begin : g_tbl
        if (i < NUM_WRITES) begin : g_used
            assign w_tbl[i] = TABLE[16*i +: 16];
        end else begin : g_pad
            assign w_tbl[i] = 16'h0000;
        end
    end

    state_t             r_state,      w_state;
    logic [1:0]         r_op,         w_op;
    logic [7:0]         r_data,       w_data;
    logic               r_valid,      w_valid;
    logic               r_busy,       w_busy;
    logic               r_done,       w_done;
    logic               r_error,      w_error;
    logic [c_IDX_W-1:0] r_idx,        w_idx;
    logic [c_RTY_W-1:0] r_retry,      w_retry;
    logic [c_GAP_W-1:0] r_gap_cnt,    w_gap_cnt;
    logic               r_retry_path, w_retry_path;
    logic               r_last_val,   w_last_val;

    logic        w_xfer;
    logic        w_nack_seen;
    logic [15:0] w_entry;

    assign w_xfer  = r_valid && Ready;
    assign w_entry = w_tbl[r_idx];
    // The STOP right after the final VAL still carries that byte's ACK status
    assign w_nack_seen = Nack && ((r_state == S_ADDR) || (r_state == S_REG) ||
                                  (r_state == S_VAL)  || ((r_state == S_STOP) && r_last_val));

    always_comb begin
        w_state      = r_state;
        w_op         = r_op;
        w_data       = r_data;
        w_valid      = r_valid;
        w_busy       = r_busy;
        w_done       = r_done;
        w_error      = r_error;
        w_idx        = r_idx;
        w_retry      = r_retry;
        w_gap_cnt    = r_gap_cnt;
        w_retry_path = r_retry_path;
        w_last_val   = 1'b0;

        if (w_nack_seen) begin
            w_op   = c_OP_STOP;
            w_data = 8'h00;
            if (r_retry == c_MAX_RETRY) begin
                w_state = S_ERR;
                w_valid = 1'b0;
                w_busy  = 1'b0;
                w_error = 1'b1;
            end else begin
                w_state      = S_STOP;
                w_valid      = 1'b1;
                w_retry      = r_retry + 1'b1;
                w_retry_path = 1'b1;
            end
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (Start) begin
                        w_state      = S_ADDR;
                        w_op         = c_OP_START;
                        w_data       = SLAVE_ADDR;
                        w_valid      = 1'b1;
                        w_busy       = 1'b1;
                        w_done       = 1'b0;
                        w_error      = 1'b0;
                        w_idx        = '0;
                        w_retry      = '0;
                        w_retry_path = 1'b0;
                    end
                end
                S_ADDR: begin
                    if (w_xfer) begin
                        w_state = S_REG;
                        w_op    = c_OP_CONT;
                        w_data  = w_entry[15:8];
                    end
                end
                S_REG: begin
                    if (w_xfer) begin
                        w_state = S_VAL;
                        w_op    = c_OP_CONT;
                        w_data  = w_entry[7:0];
                    end
                end
                S_VAL: begin
                    if (w_xfer) begin
                        if (r_idx != c_LAST_IDX) begin
                            w_state = S_ADDR;
                            w_op    = c_OP_RESTART;
                            w_data  = SLAVE_ADDR;
                            w_idx   = r_idx + 1'b1;
                            w_retry = '0;
                        end else begin
                            w_state      = S_STOP;
                            w_op         = c_OP_STOP;
                            w_data       = 8'h00;
                            w_retry_path = 1'b0;
                            w_last_val   = 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_xfer) begin
                        if (!r_retry_path) begin
                            w_state = S_DONE;
                            w_valid = 1'b0;
                            w_busy  = 1'b0;
                            w_done  = 1'b1;
                        end else if (RETRY_GAP == 0) begin
                            w_state = S_ADDR;
                            w_op    = c_OP_START;
                            w_data  = SLAVE_ADDR;
                        end else begin
                            w_state   = S_GAP;
                            w_valid   = 1'b0;
                            w_gap_cnt = '0;
                        end
                    end else begin
                        w_last_val = r_last_val;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        w_state = S_ADDR;
                        w_op    = c_OP_START;
                        w_data  = SLAVE_ADDR;
                        w_valid = 1'b1;
                    end else begin
                        w_gap_cnt = r_gap_cnt + 1'b1;
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_op         <= c_OP_STOP;
            r_data       <= 8'h00;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_idx        <= '0;
            r_retry      <= '0;
            r_gap_cnt    <= '0;
            r_retry_path <= 1'b0;
            r_last_val   <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_op         <= w_op;
            r_data       <= w_data;
            r_valid      <= w_valid;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_error      <= w_error;
            r_idx        <= w_idx;
            r_retry      <= w_retry;
            r_gap_cnt    <= w_gap_cnt;
            r_retry_path <= w_retry_path;
            r_last_val   <= w_last_val;
        end
    end

    assign Op    = r_op;
    assign Data  = r_data;
    assign Valid = r_valid;
    assign Busy  = r_busy;
    assign Done  = r_done;
    assign Error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_reg_sequencer
// Description : Directed self-checking bench; instance A has two entries with
//               a retry gap, instance B has one entry and no gap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_reg_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a_start = 1'b0, a_ready = 1'b1, a_nack = 1'b0;
    logic [1:0] a_op;
    logic [7:0] a_data;
    logic       a_valid, a_busy, a_done, a_error;

    logic       b_start = 1'b0, b_ready = 1'b1, b_nack = 1'b0;
    logic [1:0] b_op;
    logic [7:0] b_data;
    logic       b_valid, b_busy, b_done, b_error;

    int n_checks = 0;
    int n_errors = 0;

    logic [10:0] exp_seq [7];

    always #5 clk = ~clk;

    i2c_reg_sequencer #(
        .NUM_WRITES (2),
        .SLAVE_ADDR (8'h72),
        .TABLE      (32'h9803_4140),
        .MAX_RETRY  (3),
        .RETRY_GAP  (4)
    ) u_dut_a (
        .Clk   (clk),
        .Reset (rst),
        .Start (a_start),
        .Op    (a_op),
        .Data  (a_data),
        .Valid (a_valid),
        .Ready (a_ready),
        .Nack  (a_nack),
        .Busy  (a_busy),
        .Done  (a_done),
        .Error (a_error)
    );

    i2c_reg_sequencer #(
        .NUM_WRITES (1),
        .SLAVE_ADDR (8'h72),
        .TABLE      (16'h4140),
        .MAX_RETRY  (2),
        .RETRY_GAP  (0)
    ) u_dut_b (
        .Clk   (clk),
        .Reset (rst),
        .Start (b_start),
        .Op    (b_op),
        .Data  (b_data),
        .Valid (b_valid),
        .Ready (b_ready),
        .Nack  (b_nack),
        .Busy  (b_busy),
        .Done  (b_done),
        .Error (b_error)
    );

    function automatic logic [10:0] tok(input logic [1:0] op, input logic [7:0] d);
        return {1'b1, op, d};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive Start/Nack for one cycle and check the token currently presented;
    // an expected value with bit 10 clear only requires Valid=0.
    task automatic step(input bit sel_b, input logic st, input logic nk,
                        input logic [10:0] exp, input string tag);
        logic [10:0] obs;
        if (sel_b) begin
            b_start = st;
            b_nack  = nk;
            obs     = {b_valid, b_op, b_data};
        end else begin
            a_start = st;
            a_nack  = nk;
            obs     = {a_valid, a_op, a_data};
        end
        if (exp[10]) check_val(tag, 32'(obs), 32'(exp));
        else         check_val(tag, 32'(obs[10]), 32'd0);
        @(negedge clk);
    endtask

    task automatic full_seq_a(input string tag);
        step(0, 1'b1, 1'b0, 11'h000, tag);
        for (int i = 0; i < 7; i++) step(0, 1'b0, 1'b0, exp_seq[i], tag);
        check_val({tag, "_done"}, {a_done, a_busy, a_valid, a_error}, 4'b1000);
    endtask

    initial begin
        int k;
        exp_seq[0] = tok(2'd1, 8'h72);
        exp_seq[1] = tok(2'd2, 8'h41);
        exp_seq[2] = tok(2'd2, 8'h40);
        exp_seq[3] = tok(2'd3, 8'h72);
        exp_seq[4] = tok(2'd2, 8'h98);
        exp_seq[5] = tok(2'd2, 8'h03);
        exp_seq[6] = tok(2'd0, 8'h00);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("rst_a", {a_op, a_data, a_valid, a_busy, a_done, a_error}, 0);
        check_val("rst_b", {b_op, b_data, b_valid, b_busy, b_done, b_error}, 0);

        // Two entries back-to-back; a Start pulse mid-sequence must be ignored
        a_ready = 1'b1;
        step(0, 1'b1, 1'b0, 11'h000, "t1_idle");
        for (int i = 0; i < 7; i++) step(0, (i == 3), 1'b0, exp_seq[i], "t1_tok");
        check_val("t1_done", {a_done, a_busy, a_valid, a_error}, 4'b1000);

        // Restart from DONE with Ready high one cycle in three
        a_ready = 1'b0;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check_val("t2_done_clr", {a_done, a_busy}, 2'b01);
        k = 0;
        for (int c = 0; c < 60 && k < 7; c++) begin
            a_ready = (c % 3 == 2);
            check_val("t2_tok", 32'({a_valid, a_op, a_data}), 32'(exp_seq[k]));
            if (a_ready) k++;
            @(negedge clk);
        end
        check_val("t2_count", k, 7);
        a_ready = 1'b1;
        check_val("t2_done", {a_done, a_busy, a_valid}, 3'b100);

        // Nack on entry-1 REG: STOP, four idle cycles, START for entry 1 again
        step(0, 1'b1, 1'b0, 11'h000, "t3_start");
        step(0, 1'b0, 1'b0, exp_seq[0], "t3_a0");
        step(0, 1'b0, 1'b0, exp_seq[1], "t3_r0");
        step(0, 1'b0, 1'b0, exp_seq[2], "t3_v0");
        step(0, 1'b0, 1'b0, exp_seq[3], "t3_a1");
        step(0, 1'b0, 1'b1, exp_seq[4], "t3_r1_nack");
        step(0, 1'b0, 1'b0, tok(2'd0, 8'h00), "t3_stop");
        check_val("t3_gap_busy", a_busy, 1'b1);
        for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b0, 11'h000, "t3_gap");
        step(0, 1'b0, 1'b0, tok(2'd1, 8'h72), "t3_a1_retry");
        step(0, 1'b0, 1'b0, exp_seq[4], "t3_r1_retry");
        step(0, 1'b0, 1'b0, exp_seq[5], "t3_v1_retry");
        step(0, 1'b0, 1'b0, exp_seq[6], "t3_stop_end");
        check_val("t3_done", {a_done, a_busy, a_valid, a_error}, 4'b1000);

        // Reset during the VAL token, then a clean replay
        step(0, 1'b1, 1'b0, 11'h000, "t4_start");
        step(0, 1'b0, 1'b0, exp_seq[0], "t4_a0");
        step(0, 1'b0, 1'b0, exp_seq[1], "t4_r0");
        check_val("t4_v0", 32'({a_valid, a_op, a_data}), 32'(exp_seq[2]));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("t4_rst", {a_op, a_data, a_valid, a_busy, a_done, a_error}, 0);
        full_seq_a("t4_replay");

        // Single entry: START, REG, VAL, STOP
        b_ready = 1'b1;
        step(1, 1'b1, 1'b0, 11'h000, "b1_start");
        step(1, 1'b0, 1'b0, tok(2'd1, 8'h72), "b1_addr");
        step(1, 1'b0, 1'b0, tok(2'd2, 8'h41), "b1_reg");
        step(1, 1'b0, 1'b0, tok(2'd2, 8'h40), "b1_val");
        step(1, 1'b0, 1'b0, tok(2'd0, 8'h00), "b1_stop");
        check_val("b1_done", {b_done, b_busy, b_valid, b_error}, 4'b1000);

        // Nack held high: ADDR nacks count, retry-STOP nacks are ignored
        step(1, 1'b1, 1'b0, 11'h000, "b2_start");
        step(1, 1'b0, 1'b1, tok(2'd1, 8'h72), "b2_try1");
        step(1, 1'b0, 1'b1, tok(2'd0, 8'h00), "b2_stop1");
        step(1, 1'b0, 1'b1, tok(2'd1, 8'h72), "b2_try2");
        step(1, 1'b0, 1'b1, tok(2'd0, 8'h00), "b2_stop2");
        step(1, 1'b0, 1'b1, tok(2'd1, 8'h72), "b2_try3");
        step(1, 1'b0, 1'b0, 11'h000, "b2_err_valid");
        check_val("b2_err", {b_error, b_busy, b_valid, b_done}, 4'b1000);

        // Nack in the cycle after the last VAL transfer forces a retry
        step(1, 1'b1, 1'b0, 11'h000, "b3_start");
        check_val("b3_err_clr", {b_error, b_busy}, 2'b01);
        step(1, 1'b0, 1'b0, tok(2'd1, 8'h72), "b3_addr");
        step(1, 1'b0, 1'b0, tok(2'd2, 8'h41), "b3_reg");
        step(1, 1'b0, 1'b0, tok(2'd2, 8'h40), "b3_val");
        step(1, 1'b0, 1'b1, tok(2'd0, 8'h00), "b3_stop_nack");
        step(1, 1'b0, 1'b0, tok(2'd0, 8'h00), "b3_retry_stop");
        step(1, 1'b0, 1'b0, tok(2'd1, 8'h72), "b3_addr2");
        step(1, 1'b0, 1'b0, tok(2'd2, 8'h41), "b3_reg2");
        step(1, 1'b0, 1'b0, tok(2'd2, 8'h40), "b3_val2");
        step(1, 1'b0, 1'b0, tok(2'd0, 8'h00), "b3_stop2");
        step(1, 1'b0, 1'b1, 11'h000, "b3_done_nack");
        b_nack = 1'b0;
        check_val("b3_done", {b_done, b_busy, b_valid, b_error}, 4'b1000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
Parametrised I2C register-write sequencer. It replaces the hard-coded 32-step feed with a table of NUM_WRITES {register, value} pairs, a Valid/Ready token handshake to the I2C master, NACK-driven retry and completion/error status. It sits between the top-level init control and the I2C master and configures the HDMI transmitter, or any single-slave device, after power-up.

Parameters:
NUM_WRITES, 8, number of register writes in the table (1..256)
SLAVE_ADDR, 8'h72, 8-bit write address byte sent after every START/RESTART
TABLE, all zeros, NUM_WRITES*16-bit flat vector; entry i = TABLE[16*i+15 : 16*i], bits [15:8] = register address, [7:0] = value
MAX_RETRY, 3, retries allowed per entry after a NACK before Error
RETRY_GAP, 16, idle cycles between a retry STOP and the next START (0 allowed)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Start  in  1  1-cycle pulse; begins the sequence from entry 0
Op  out  2  token opcode: 0 STOP, 1 START, 2 CONTINUE, 3 RESTART
Data  out  8  token byte; 0 for STOP tokens
Valid  out  1  token on Op/Data is valid
Ready  in  1  master accepts the token when Valid && Ready
Nack  in  1  1-cycle pulse from master: last byte was not acknowledged
Busy  out  1  sequence in progress, including retry gap and final STOP
Done  out  1  level; all entries written and STOP accepted
Error  out  1  level; retries exhausted

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high. All outputs are registered.
- Reset values: Op=0, Data=0, Valid=0, Busy=0, Done=0, Error=0. Entry index=0, retry count=0, state IDLE.
- Reset mid-operation: abort immediately. No STOP token is emitted.
- States: IDLE, ADDR, REG, VAL, STOP, GAP, DONE, ERR.
- IDLE/DONE/ERR + Start:
  - Clear Done, Error, index and retry count.
  - Go to ADDR. Valid=1 on the next cycle.
  - Latency: Start in cycle n gives token {START, SLAVE_ADDR} valid in cycle n+1.
- Start while Busy: ignored.
- ADDR token:
  - Op=START for entry 0 and for the first token after GAP.
  - Op=RESTART for later entries in the same transaction.
  - Data=SLAVE_ADDR.
- REG token: {CONTINUE, TABLE reg byte[index]}.
- VAL token: {CONTINUE, TABLE value byte[index]}.
- Handshake:
  - A token transfers when Valid && Ready.
  - Op/Data/Valid hold stable while Valid && !Ready.
  - On transfer, the next token is presented the following cycle, back-to-back, so Valid stays high.
- After VAL is accepted:
  - If index < NUM_WRITES-1: index++, retry count := 0, go to ADDR (RESTART).
  - Else go to STOP.
- STOP token: {STOP, 0}.
  - If accepted after the last entry: Valid=0, Busy=0, Done=1, go to DONE.
  - If accepted on the retry path: go to GAP.
- NACK:
  - Nack is sampled in ADDR/REG/VAL, and also in the cycle after the last VAL transfer.
  - Nack has priority over a simultaneous handshake; that token counts as consumed.
  - If retry count == MAX_RETRY: Valid=0, Busy=0, Error=1, go to ERR. The index stays on the failing entry for debug.
  - Otherwise: retry count++, go to STOP (retry path).
  - Nack in STOP, GAP or IDLE is ignored.
- GAP:
  - Valid=0. Count RETRY_GAP cycles, then go to ADDR with Op=START for the same entry.
  - RETRY_GAP=0: go to ADDR on the next cycle.
- Width rules:
  - Index width = max(1, clog2(NUM_WRITES)). The index never wraps past NUM_WRITES-1.
  - Retry counter width = clog2(MAX_RETRY+1).
- NUM_WRITES=1: token sequence is START, REG, VAL, STOP.

Test Plan:
- NUM_WRITES=2, TABLE={16'h9803 (entry 1), 16'h4140 (entry 0)}, Ready tied 1, Start pulse:
  - Required tokens: {1,72} {2,41} {2,40} {3,72} {2,98} {2,03} {0,00} on consecutive cycles from n+1.
  - Done=1 and Busy=0 in the cycle after STOP is accepted.
- Same table, Ready toggling 1-of-3 cycles: identical token order; Op/Data never change while Valid && !Ready.
- Nack pulse during entry-1 REG token, MAX_RETRY=3, RETRY_GAP=4:
  - Required: {0,00} STOP, exactly 4 Valid=0 cycles, then {1,72} {2,98} {2,03}, then STOP, Done=1.
- Nack on every ADDR token, MAX_RETRY=2: three START attempts, two retry STOPs, then Error=1, Busy=0, Valid=0, Done=0.
- Reset asserted mid-VAL with Valid=1: next cycle all outputs are 0. A later Start replays from entry 0 with START.
- Start pulsed while Busy, and Start pulsed from DONE:
  - Busy case: no effect.
  - DONE case: Done clears next cycle and the full sequence repeats.
